// File: rtl/usb_line_if.sv
// usb_line_if - full-speed USB line interface.
//
// Synchronizes the raw D+/D- pad levels, decodes them into J/K/SE0/SE1 line
// state, drives the pads from the device core's transmit request, and detects
// bus reset (long SE0), suspend (long idle J) and resume (suspend exit).
//
// Ports:
//   clk, rst                     48 MHz clock, synchronous active-high reset
//   i_dp, i_dn                   raw pad levels (asynchronous to clk)
//   o_usb_j_not_k, o_usb_se0     decoded receive line state
//   o_se1                        illegal SE1 (dp=dn=1) currently decoded
//   i_tx_oe, i_tx_j_not_k,
//   i_tx_se0                     transmit request from the device core
//   o_dp, o_dn, o_pad_oe         registered pad drive and output enable
//   o_bus_reset                  level, bus reset in progress
//   o_suspend                    level, bus suspended
//   o_resume                     one-cycle pulse on suspend exit
//
// Configuration macro: USB_LINE_FILTER_EN adds a 3-sample majority glitch
// filter after the synchronizers (decode latency 5 cycles instead of 3).

module usb_line_if #(
    parameter int unsigned RESET_CYCLES   = 120,
    parameter int unsigned SUSPEND_CYCLES = 144000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dp,
    input  logic i_dn,
    output logic o_usb_j_not_k,
    output logic o_usb_se0,
    input  logic i_tx_oe,
    input  logic i_tx_j_not_k,
    input  logic i_tx_se0,
    output logic o_dp,
    output logic o_dn,
    output logic o_pad_oe,
    output logic o_bus_reset,
    output logic o_suspend,
    output logic o_resume,
    output logic o_se1
);

    localparam int unsigned RST_CNT_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned SUSP_CNT_W = $clog2(SUSPEND_CYCLES + 1);
    localparam logic [RST_CNT_W-1:0]  RST_CNT_MAX  = RST_CNT_W'(RESET_CYCLES);
    localparam logic [SUSP_CNT_W-1:0] SUSP_CNT_MAX = SUSP_CNT_W'(SUSPEND_CYCLES);

    // Line pairs are packed as {dp, dn}; idle J is 2'b10.
    localparam logic [1:0] LINE_J = 2'b10;

    logic [1:0] line_sync1_q, line_sync1_d;
    logic [1:0] line_sync2_q, line_sync2_d;
    logic [1:0] line_filt;

`ifdef USB_LINE_FILTER_EN
    // The second synchronizer flop is the newest of the three samples, so the
    // window is {sync2, sh0, sh1}; with the registered vote this adds 2 cycles.
    logic [1:0] filt_sh0_q, filt_sh0_d;
    logic [1:0] filt_sh1_q, filt_sh1_d;
    logic [1:0] filt_maj_q, filt_maj_d;
`endif

    logic                  j_not_k_q, j_not_k_d;
    logic                  se0_q, se0_d;
    logic                  se1_q, se1_d;
    logic                  line_is_j;
    logic [RST_CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [SUSP_CNT_W-1:0] susp_cnt_q, susp_cnt_d;
    logic                  bus_reset_q, bus_reset_d;
    logic                  suspend_q, suspend_d;
    logic                  resume_q, resume_d;
    logic                  pad_oe_q, pad_oe_d;
    logic                  dp_q, dp_d;
    logic                  dn_q, dn_d;

    always_comb begin
        line_sync1_d = {i_dp, i_dn};
        line_sync2_d = line_sync1_q;

`ifdef USB_LINE_FILTER_EN
        filt_sh0_d = line_sync2_q;
        filt_sh1_d = filt_sh0_q;
        filt_maj_d = (line_sync2_q & filt_sh0_q) | (line_sync2_q & filt_sh1_q) |
                     (filt_sh0_q & filt_sh1_q);
        line_filt  = filt_maj_q;
`else
        line_filt  = line_sync2_q;
`endif

        // Decode; SE1 keeps the last J/K indication.
        j_not_k_d = j_not_k_q;
        se0_d     = 1'b0;
        se1_d     = 1'b0;
        unique case (line_filt)
            2'b10: j_not_k_d = 1'b1;
            2'b01: j_not_k_d = 1'b0;
            2'b00: begin
                j_not_k_d = 1'b0;
                se0_d     = 1'b1;
            end
            default: se1_d = 1'b1;
        endcase

        line_is_j = j_not_k_q & ~se0_q & ~se1_q;

        // Saturating counters; any other decoded state (including SE1) clears.
        if (se0_q) begin
            rst_cnt_d = (rst_cnt_q == RST_CNT_MAX) ? rst_cnt_q : rst_cnt_q + RST_CNT_W'(1);
        end else begin
            rst_cnt_d = '0;
        end

        if (line_is_j && !i_tx_oe) begin
            susp_cnt_d = (susp_cnt_q == SUSP_CNT_MAX) ? susp_cnt_q :
                                                        susp_cnt_q + SUSP_CNT_W'(1);
        end else begin
            susp_cnt_d = '0;
        end

        // Registered from the next counter value, so the flag tracks the counter
        // with no extra cycle of lag in either direction.
        bus_reset_d = (rst_cnt_d == RST_CNT_MAX);
        suspend_d   = (susp_cnt_d == SUSP_CNT_MAX);
        // A suspend exit caused by SE1 alone is not a resume.
        resume_d    = suspend_q & ~suspend_d & ~se1_q;

        pad_oe_d = i_tx_oe;
        dp_d     = i_tx_oe & ~i_tx_se0 & i_tx_j_not_k;
        dn_d     = i_tx_oe & ~i_tx_se0 & ~i_tx_j_not_k;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_sync1_q <= LINE_J;
            line_sync2_q <= LINE_J;
`ifdef USB_LINE_FILTER_EN
            filt_sh0_q   <= LINE_J;
            filt_sh1_q   <= LINE_J;
            filt_maj_q   <= LINE_J;
`endif
            j_not_k_q    <= 1'b1;
            se0_q        <= 1'b0;
            se1_q        <= 1'b0;
            rst_cnt_q    <= '0;
            susp_cnt_q   <= '0;
            bus_reset_q  <= 1'b0;
            suspend_q    <= 1'b0;
            resume_q     <= 1'b0;
            pad_oe_q     <= 1'b0;
            dp_q         <= 1'b0;
            dn_q         <= 1'b0;
        end else begin
            line_sync1_q <= line_sync1_d;
            line_sync2_q <= line_sync2_d;
`ifdef USB_LINE_FILTER_EN
            filt_sh0_q   <= filt_sh0_d;
            filt_sh1_q   <= filt_sh1_d;
            filt_maj_q   <= filt_maj_d;
`endif
            j_not_k_q    <= j_not_k_d;
            se0_q        <= se0_d;
            se1_q        <= se1_d;
            rst_cnt_q    <= rst_cnt_d;
            susp_cnt_q   <= susp_cnt_d;
            bus_reset_q  <= bus_reset_d;
            suspend_q    <= suspend_d;
            resume_q     <= resume_d;
            pad_oe_q     <= pad_oe_d;
            dp_q         <= dp_d;
            dn_q         <= dn_d;
        end
    end

    assign o_usb_j_not_k = j_not_k_q;
    assign o_usb_se0     = se0_q;
    assign o_se1         = se1_q;
    assign o_bus_reset   = bus_reset_q;
    assign o_suspend     = suspend_q;
    assign o_resume      = resume_q;
    assign o_pad_oe      = pad_oe_q;
    assign o_dp          = dp_q;
    assign o_dn          = dn_q;

endmodule

// File: tb/tb_usb_line_if.sv
// Directed bench for usb_line_if: steady-state vector table plus hand-written
// latency, bus reset, suspend/resume, SE1, glitch and mid-operation reset cases.

module tb_usb_line_if;

`ifdef USB_LINE_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic i_dp, i_dn;
    logic i_tx_oe, i_tx_j_not_k, i_tx_se0;
    logic o_usb_j_not_k, o_usb_se0, o_se1;
    logic o_dp, o_dn, o_pad_oe;
    logic o_bus_reset, o_suspend, o_resume;

    always #5 clk = ~clk;

    usb_line_if #(
        .RESET_CYCLES  (120),
        .SUSPEND_CYCLES(1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_dp         (i_dp),
        .i_dn         (i_dn),
        .o_usb_j_not_k(o_usb_j_not_k),
        .o_usb_se0    (o_usb_se0),
        .i_tx_oe      (i_tx_oe),
        .i_tx_j_not_k (i_tx_j_not_k),
        .i_tx_se0     (i_tx_se0),
        .o_dp         (o_dp),
        .o_dn         (o_dn),
        .o_pad_oe     (o_pad_oe),
        .o_bus_reset  (o_bus_reset),
        .o_suspend    (o_suspend),
        .o_resume     (o_resume),
        .o_se1        (o_se1)
    );

    typedef struct {
        logic dp, dn, oe, tj, tse0;
        logic ej, es0, es1, edp, edn, eoe;
    } vec_t;

    vec_t vt[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pads(input logic dp, input logic dn);
        i_dp = dp;
        i_dn = dn;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_j"},      int'(o_usb_j_not_k), 1);
        chk({tag, "_se0"},    int'(o_usb_se0), 0);
        chk({tag, "_se1"},    int'(o_se1), 0);
        chk({tag, "_oe"},     int'(o_pad_oe), 0);
        chk({tag, "_dp"},     int'(o_dp), 0);
        chk({tag, "_dn"},     int'(o_dn), 0);
        chk({tag, "_busrst"}, int'(o_bus_reset), 0);
        chk({tag, "_susp"},   int'(o_suspend), 0);
        chk({tag, "_resume"}, int'(o_resume), 0);
    endtask

    initial begin
        int seen;
        int lows;
        logic [2:0] tpat;

        //          dp    dn    oe    tj    tse0  ej    es0   es1   edp   edn   eoe
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset overrides non-idle pads and an active transmit request.
        rst = 1'b1;
        pads(1'b0, 1'b0);
        i_tx_oe = 1'b1;
        i_tx_j_not_k = 1'b1;
        i_tx_se0 = 1'b0;
        step(3);
        chk_reset_vals("por");

        rst = 1'b0;
        pads(1'b1, 1'b0);
        i_tx_oe = 1'b0;
        step(LAT + 2);

        // J -> K decode latency.
        pads(1'b0, 1'b1);
        step(LAT - 1);
        chk("lat_before", int'(o_usb_j_not_k), 1);
        step(1);
        chk("lat_at", int'(o_usb_j_not_k), 0);

        // Steady-state decode and transmit table.
        for (int i = 0; i < 7; i++) begin
            pads(vt[i].dp, vt[i].dn);
            i_tx_oe = vt[i].oe;
            i_tx_j_not_k = vt[i].tj;
            i_tx_se0 = vt[i].tse0;
            step(LAT + 3);
            chk($sformatf("vec%0d_j", i),   int'(o_usb_j_not_k), int'(vt[i].ej));
            chk($sformatf("vec%0d_se0", i), int'(o_usb_se0), int'(vt[i].es0));
            chk($sformatf("vec%0d_se1", i), int'(o_se1), int'(vt[i].es1));
            chk($sformatf("vec%0d_dp", i),  int'(o_dp), int'(vt[i].edp));
            chk($sformatf("vec%0d_dn", i),  int'(o_dn), int'(vt[i].edn));
            chk($sformatf("vec%0d_oe", i),  int'(o_pad_oe), int'(vt[i].eoe));
        end

        // Transmit toggling, one-cycle latency.
        tpat = 3'b101;
        i_tx_oe = 1'b1;
        i_tx_se0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_tx_j_not_k = tpat[2-i];
            step(1);
            chk($sformatf("txtog%0d_dp", i), int'(o_dp), int'(tpat[2-i]));
            chk($sformatf("txtog%0d_dn", i), int'(o_dn), int'(!tpat[2-i]));
        end
        i_tx_se0 = 1'b1;
        step(1);
        chk("txse0_dp", int'(o_dp), 0);
        chk("txse0_dn", int'(o_dn), 0);
        chk("txse0_oe", int'(o_pad_oe), 1);
        i_tx_oe = 1'b0;
        i_tx_se0 = 1'b0;

        // 119 SE0 cycles: no bus reset.
        pads(1'b1, 1'b0);
        step(LAT + 2);
        pads(1'b0, 1'b0);
        seen = 0;
        for (int e = 0; e < 119 + LAT + 5; e++) begin
            if (e == 119) pads(1'b1, 1'b0);
            step(1);
            if (o_bus_reset) seen = 1;
        end
        chk("se0_119_no_reset", seen, 0);

        // Long SE0: bus reset at decode-cycle 121, drops one cycle after J.
        pads(1'b0, 1'b0);
        step(LAT + 119);
        chk("busrst_before", int'(o_bus_reset), 0);
        step(1);
        chk("busrst_rise", int'(o_bus_reset), 1);
        step(79);
        chk("busrst_hold", int'(o_bus_reset), 1);
        pads(1'b1, 1'b0);
        step(LAT);
        chk("busrst_jdecode_j", int'(o_usb_j_not_k), 1);
        chk("busrst_jdecode_still", int'(o_bus_reset), 1);
        step(1);
        chk("busrst_fall", int'(o_bus_reset), 0);

        // Idle J for 1000 decode cycles -> suspend; K -> resume pulse.
        step(998);
        chk("susp_before", int'(o_suspend), 0);
        step(1);
        chk("susp_rise", int'(o_suspend), 1);
        pads(1'b0, 1'b1);
        step(LAT);
        chk("k_susp_still", int'(o_suspend), 1);
        chk("k_resume_not_yet", int'(o_resume), 0);
        step(1);
        chk("k_susp_fall", int'(o_suspend), 0);
        chk("k_resume_pulse", int'(o_resume), 1);
        step(1);
        chk("k_resume_end", int'(o_resume), 0);

        // SE0 during suspend: resume pulse, then bus reset after 120 cycles.
        pads(1'b1, 1'b0);
        step(LAT + 1002);
        chk("susp2_up", int'(o_suspend), 1);
        pads(1'b0, 1'b0);
        step(LAT + 1);
        chk("se0_susp_fall", int'(o_suspend), 0);
        chk("se0_resume_pulse", int'(o_resume), 1);
        step(1);
        chk("se0_resume_end", int'(o_resume), 0);
        step(117);
        chk("se0_busrst_before", int'(o_bus_reset), 0);
        step(1);
        chk("se0_busrst_rise", int'(o_bus_reset), 1);

        // Transmitting on idle-J receive never suspends.
        pads(1'b1, 1'b0);
        i_tx_oe = 1'b1;
        i_tx_j_not_k = 1'b1;
        seen = 0;
        for (int e = 0; e < 2000 + LAT; e++) begin
            step(1);
            if (o_suspend) seen = 1;
        end
        chk("txoe_no_suspend", seen, 0);
        chk("txoe_busrst_gone", int'(o_bus_reset), 0);
        i_tx_oe = 1'b0;

        // SE1 for 5 cycles after J: se1 for exactly 5 decode cycles, J/K held.
        step(2);
        pads(1'b1, 1'b1);
        for (int e = 1; e <= LAT + 6; e++) begin
            step(1);
            if (e == 5) pads(1'b1, 1'b0);
            chk($sformatf("se1_e%0d_se1", e), int'(o_se1),
                (e >= LAT && e <= LAT + 4) ? 1 : 0);
            chk($sformatf("se1_e%0d_j", e), int'(o_usb_j_not_k), 1);
        end

        // SE1 between two 100-cycle SE0 runs clears the reset counter.
        pads(1'b0, 1'b0);
        seen = 0;
        for (int e = 0; e < 203 + LAT + 3; e++) begin
            if (e == 100) pads(1'b1, 1'b1);
            if (e == 103) pads(1'b0, 1'b0);
            if (e == 203) pads(1'b1, 1'b0);
            step(1);
            if (o_bus_reset) seen = 1;
        end
        chk("se1_clears_rstcnt", seen, 0);
        step(LAT + 2);

        // Single-cycle K glitch inside J.
        pads(1'b0, 1'b1);
        lows = 0;
        for (int e = 1; e <= LAT + 4; e++) begin
            step(1);
            if (e == 1) pads(1'b1, 1'b0);
            if (!o_usb_j_not_k) lows++;
        end
`ifdef USB_LINE_FILTER_EN
        chk("glitch_low_cycles", lows, 0);
`else
        chk("glitch_low_cycles", lows, 1);
`endif

        // Reset at SE0 cycle ~100 while transmitting.
        pads(1'b0, 1'b0);
        i_tx_oe = 1'b1;
        i_tx_j_not_k = 1'b1;
        step(LAT + 100);
        chk("midrst_tx_dp", int'(o_dp), 1);
        rst = 1'b1;
        step(1);
        chk_reset_vals("midrst");
        rst = 1'b0;
        i_tx_oe = 1'b0;
        step(LAT + 119);
        chk("midrst_busrst_before", int'(o_bus_reset), 0);
        chk("midrst_no_resume", int'(o_resume), 0);
        step(1);
        chk("midrst_busrst_fresh", int'(o_bus_reset), 1);

        // Reset while suspended: no resume pulse.
        pads(1'b1, 1'b0);
        step(LAT + 1003);
        chk("rstsusp_up", int'(o_suspend), 1);
        rst = 1'b1;
        step(1);
        chk("rstsusp_susp", int'(o_suspend), 0);
        chk("rstsusp_resume0", int'(o_resume), 0);
        rst = 1'b0;
        step(1);
        chk("rstsusp_resume1", int'(o_resume), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
